// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage CPU: drives PC/IF-ID/ID-EX/EX-ME
// enables and flushes for load-use, branch, divide and debug-halt conditions.
module pipeline_hazard_ctrl #(
  parameter int DIV_MAX_CYCLES = 40,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             debug,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             EX_ctl_dataRam_en,
  input  logic             EX_ctl_dataRam_wen,
  input  logic             EX_ctl_rf_wen,
  input  logic [4:0]       EX_reg_waddr,
  input  logic             EX_is_div,
  input  logic             div_done,
  input  logic             ME_pc_control,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_ME_flush,
  output logic             div_start,
  output logic             div_abort,
  output logic             div_busy,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [15:0]      flush_count
);

  localparam int WD_W = ($clog2(DIV_MAX_CYCLES) < 1) ? 1 : $clog2(DIV_MAX_CYCLES);

  typedef enum logic [1:0] {
    RUN,
    DIV_WAIT,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              div_timeout_q, div_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [15:0]       flush_count_q, flush_count_d;
  logic              load_use;
  logic              wd_expired;

  assign load_use = EX_ctl_dataRam_en & ~EX_ctl_dataRam_wen & EX_ctl_rf_wen &
                    (EX_reg_waddr != 5'd0) &
                    ((ID_uses_rs & (ID_rs == EX_reg_waddr)) |
                     (ID_uses_rt & (ID_rt == EX_reg_waddr)));

  assign wd_expired = (wd_q == WD_W'(DIV_MAX_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    div_timeout_d = div_timeout_q;
    flush_count_d = flush_count_q;
    pc_en         = 1'b1;
    IF_ID_en      = 1'b1;
    ID_EX_en      = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_ME_flush   = 1'b0;
    div_start     = 1'b0;
    div_abort     = 1'b0;
    div_busy      = 1'b0;

    // During reset every output stays at its RUN no-hazard value
    if (!reset) begin
      div_busy = (state_q == DIV_WAIT);
      if (debug || state_q == HALT) begin
        pc_en       = 1'b0;
        IF_ID_en    = 1'b0;
        ID_EX_en    = 1'b0;
        ID_EX_flush = 1'b1;
        EX_ME_flush = 1'b1;
        wd_d        = '0;
        state_d     = debug ? HALT : RUN;
        div_abort   = debug && (state_q == DIV_WAIT);
      end else begin
        case (state_q)
          RUN: begin
            // EX holds a wrong-path instruction on a taken branch, so it wins
            if (ME_pc_control) begin
              IF_ID_flush   = 1'b1;
              ID_EX_flush   = 1'b1;
              EX_ME_flush   = 1'b1;
              flush_count_d = flush_count_q + 16'd1;
            end else if (EX_is_div) begin
              div_start   = 1'b1;
              pc_en       = 1'b0;
              IF_ID_en    = 1'b0;
              ID_EX_en    = 1'b0;
              EX_ME_flush = 1'b1;
              wd_d        = '0;
              state_d     = DIV_WAIT;
            end else if (load_use) begin
              pc_en       = 1'b0;
              IF_ID_en    = 1'b0;
              ID_EX_flush = 1'b1;
            end
          end
          DIV_WAIT: begin
            if (div_done) begin
              wd_d    = '0;
              state_d = RUN;
            end else if (wd_expired) begin
              wd_d          = '0;
              state_d       = RUN;
              div_timeout_d = 1'b1;
              div_abort     = 1'b1;
            end else begin
              pc_en       = 1'b0;
              IF_ID_en    = 1'b0;
              ID_EX_en    = 1'b0;
              EX_ME_flush = 1'b1;
              wd_d        = wd_q + WD_W'(1);
            end
          end
          default: state_d = RUN;
        endcase
      end
    end

    stall_cycles_d = stall_cycles_q;
    if (!pc_en && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wd_q           <= '0;
      div_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      div_timeout_q  <= div_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign div_timeout  = div_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: load-use, branch, divide,
// watchdog, debug halt and reset-during-divide sequences.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        debug;
  logic [4:0]  ID_rs, ID_rt, EX_reg_waddr;
  logic        ID_uses_rs, ID_uses_rt;
  logic        EX_ctl_dataRam_en, EX_ctl_dataRam_wen, EX_ctl_rf_wen;
  logic        EX_is_div, div_done, ME_pc_control;
  logic        pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_ME_flush;
  logic        div_start, div_abort, div_busy, div_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int vectorCount = 0;
  int missCount   = 0;
  int busyCount;
  int abortCount;
  int exitAt;

  pipeline_hazard_ctrl #(.DIV_MAX_CYCLES(40), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .debug(debug),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .EX_ctl_dataRam_en(EX_ctl_dataRam_en), .EX_ctl_dataRam_wen(EX_ctl_dataRam_wen),
    .EX_ctl_rf_wen(EX_ctl_rf_wen), .EX_reg_waddr(EX_reg_waddr),
    .EX_is_div(EX_is_div), .div_done(div_done), .ME_pc_control(ME_pc_control),
    .pc_en(pc_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush),
    .ID_EX_en(ID_EX_en), .ID_EX_flush(ID_EX_flush), .EX_ME_flush(EX_ME_flush),
    .div_start(div_start), .div_abort(div_abort), .div_busy(div_busy),
    .div_timeout(div_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // ldKind: 0 none, 1 load, 2 store (rf_wen kept high), 3 load without rf_wen
  task automatic applyStimulus(input logic dbg, input logic br, input logic isDiv, input logic done,
                               input int ldKind, input logic [4:0] waddr, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs, input logic urt);
    debug              = dbg;
    ME_pc_control      = br;
    EX_is_div          = isDiv;
    div_done           = done;
    EX_ctl_dataRam_en  = (ldKind != 0);
    EX_ctl_dataRam_wen = (ldKind == 2);
    EX_ctl_rf_wen      = (ldKind == 1) || (ldKind == 2);
    EX_reg_waddr       = waddr;
    ID_rs              = rs;
    ID_rt              = rt;
    ID_uses_rs         = urs;
    ID_uses_rt         = urt;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset cycle with every hazard source asserted: outputs must be RUN defaults
    reset = 1'b1;
    applyStimulus(1, 1, 1, 0, 1, 5'd2, 5'd2, 5'd2, 1, 1);
    checkOutput("rst_pc_en", pc_en, 1);
    checkOutput("rst_if_id_en", IF_ID_en, 1);
    checkOutput("rst_id_ex_en", ID_EX_en, 1);
    checkOutput("rst_if_id_flush", IF_ID_flush, 0);
    checkOutput("rst_id_ex_flush", ID_EX_flush, 0);
    checkOutput("rst_ex_me_flush", EX_ME_flush, 0);
    checkOutput("rst_div_start", div_start, 0);
    checkOutput("rst_div_abort", div_abort, 0);
    checkOutput("rst_div_busy", div_busy, 0);
    nextCycle();
    reset = 1'b0;
    idle();
    checkOutput("post_rst_stall", stall_cycles, 0);
    checkOutput("post_rst_flush", flush_count, 0);
    checkOutput("post_rst_timeout", div_timeout, 0);
    checkOutput("post_rst_pc_en", pc_en, 1);
    nextCycle();

    // Load-use on rs
    applyStimulus(0, 0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 1, 0);
    checkOutput("lu_pc_en", pc_en, 0);
    checkOutput("lu_if_id_en", IF_ID_en, 0);
    checkOutput("lu_id_ex_flush", ID_EX_flush, 1);
    checkOutput("lu_id_ex_en", ID_EX_en, 1);
    checkOutput("lu_ex_me_flush", EX_ME_flush, 0);
    nextCycle();
    idle();
    checkOutput("lu_stall_cnt", stall_cycles, 1);
    checkOutput("lu_released", pc_en, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
    checkOutput("lu_r0_pc_en", pc_en, 1);
    checkOutput("lu_r0_flush", ID_EX_flush, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 2, 5'd2, 5'd2, 5'd0, 1, 0);
    checkOutput("lu_store_pc_en", pc_en, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 3, 5'd2, 5'd2, 5'd0, 1, 0);
    checkOutput("lu_norf_pc_en", pc_en, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd7, 1, 0);
    checkOutput("lu_rt_unused_pc_en", pc_en, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd7, 0, 1);
    checkOutput("lu_rt_pc_en", pc_en, 0);
    checkOutput("lu_rt_flush", ID_EX_flush, 1);
    nextCycle();

    // Branch together with a load-use hazard
    applyStimulus(0, 1, 0, 0, 1, 5'd2, 5'd2, 5'd0, 1, 0);
    checkOutput("br_pc_en", pc_en, 1);
    checkOutput("br_if_id_en", IF_ID_en, 1);
    checkOutput("br_if_id_flush", IF_ID_flush, 1);
    checkOutput("br_id_ex_flush", ID_EX_flush, 1);
    checkOutput("br_ex_me_flush", EX_ME_flush, 1);
    checkOutput("br_stall_before", stall_cycles, 2);
    nextCycle();
    idle();
    checkOutput("br_flush_cnt", flush_count, 1);
    checkOutput("br_stall_after", stall_cycles, 2);
    checkOutput("br_if_id_flush_off", IF_ID_flush, 0);
    nextCycle();
    applyStimulus(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    checkOutput("br_div_no_start", div_start, 0);
    checkOutput("br_div_pc_en", pc_en, 1);
    nextCycle();
    idle();
    checkOutput("br_div_flush_cnt", flush_count, 2);
    checkOutput("br_div_no_busy", div_busy, 0);
    nextCycle();

    // Divide: entry cycle, then done arrives in the 11th DIV_WAIT cycle
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    checkOutput("div_start", div_start, 1);
    checkOutput("div_entry_pc_en", pc_en, 0);
    checkOutput("div_entry_if_id_en", IF_ID_en, 0);
    checkOutput("div_entry_id_ex_en", ID_EX_en, 0);
    checkOutput("div_entry_ex_me_flush", EX_ME_flush, 1);
    checkOutput("div_entry_busy", div_busy, 0);
    nextCycle();
    busyCount = 0;
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(0, 0, 1, (i == 11), 0, 5'd0, 5'd0, 5'd0, 0, 0);
      if (div_busy) busyCount++;
      if (i == 1) begin
        checkOutput("div_wait_no_start", div_start, 0);
        checkOutput("div_wait_pc_en", pc_en, 0);
        checkOutput("div_wait_ex_me_flush", EX_ME_flush, 1);
      end
      if (i == 11) begin
        checkOutput("div_done_pc_en", pc_en, 1);
        checkOutput("div_done_if_id_en", IF_ID_en, 1);
        checkOutput("div_done_id_ex_en", ID_EX_en, 1);
        checkOutput("div_done_ex_me_flush", EX_ME_flush, 0);
        checkOutput("div_done_no_abort", div_abort, 0);
      end
      nextCycle();
    end
    checkOutput("div_busy_cycles", busyCount, 11);
    idle();
    checkOutput("div_run_busy", div_busy, 0);
    checkOutput("div_run_pc_en", pc_en, 1);
    checkOutput("div_stall_cnt", stall_cycles, 13);
    nextCycle();

    // Watchdog: done never arrives
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    checkOutput("wd_start", div_start, 1);
    nextCycle();
    exitAt = 0;
    abortCount = 0;
    for (int i = 1; i <= 60 && exitAt == 0; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      if (div_abort) abortCount++;
      if (pc_en) exitAt = i;
      nextCycle();
    end
    checkOutput("wd_exit_cycle", exitAt, 40);
    checkOutput("wd_abort_pulses", abortCount, 1);
    idle();
    checkOutput("wd_timeout", div_timeout, 1);
    checkOutput("wd_busy_off", div_busy, 0);
    checkOutput("wd_stall_cnt", stall_cycles, 53);
    nextCycle();
    idle();
    checkOutput("wd_timeout_sticky", div_timeout, 1);
    nextCycle();

    // Debug raised during DIV_WAIT
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    checkOutput("dbg_abort", div_abort, 1);
    checkOutput("dbg_pc_en", pc_en, 0);
    checkOutput("dbg_if_id_en", IF_ID_en, 0);
    checkOutput("dbg_id_ex_en", ID_EX_en, 0);
    checkOutput("dbg_id_ex_flush", ID_EX_flush, 1);
    checkOutput("dbg_ex_me_flush", EX_ME_flush, 1);
    checkOutput("dbg_busy_in_wait", div_busy, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    checkOutput("halt_no_abort", div_abort, 0);
    checkOutput("halt_busy", div_busy, 0);
    checkOutput("halt_pc_en", pc_en, 0);
    checkOutput("halt_ex_me_flush", EX_ME_flush, 1);
    nextCycle();
    idle();
    checkOutput("halt_exit_pc_en", pc_en, 0);
    nextCycle();
    idle();
    checkOutput("run_pc_en", pc_en, 1);
    checkOutput("run_if_id_en", IF_ID_en, 1);
    checkOutput("run_id_ex_en", ID_EX_en, 1);
    checkOutput("run_id_ex_flush", ID_EX_flush, 0);
    checkOutput("dbg_stall_cnt", stall_cycles, 58);
    checkOutput("dbg_timeout_kept", div_timeout, 1);
    nextCycle();

    // Debug in RUN beats a divide entry
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    checkOutput("dbg_run_no_start", div_start, 0);
    checkOutput("dbg_run_pc_en", pc_en, 0);
    nextCycle();
    idle();
    checkOutput("dbg_run_halt_pc_en", pc_en, 0);
    nextCycle();
    idle();
    checkOutput("dbg_run_back_pc_en", pc_en, 1);
    checkOutput("dbg_run_no_busy", div_busy, 0);
    checkOutput("dbg_run_stall_cnt", stall_cycles, 60);
    nextCycle();

    // Reset asserted mid-DIV_WAIT
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    checkOutput("rstdiv_no_abort", div_abort, 0);
    checkOutput("rstdiv_busy", div_busy, 0);
    checkOutput("rstdiv_pc_en", pc_en, 1);
    nextCycle();
    reset = 1'b0;
    idle();
    checkOutput("rstdiv_run_busy", div_busy, 0);
    checkOutput("rstdiv_run_pc_en", pc_en, 1);
    checkOutput("rstdiv_stall", stall_cycles, 0);
    checkOutput("rstdiv_flush", flush_count, 0);
    checkOutput("rstdiv_timeout", div_timeout, 0);
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
